// File: rtl/magma_block_sequencer_if.sv
// Magma block sequencer bus: input stream, cipher core side, result stream.
// The sequencer takes the slave view; the environment drives the master view.
interface magma_block_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        in_encr_decr;
    logic        core_start;
    logic [63:0] core_data_in;
    logic        core_encr_decr;
    logic        core_done;
    logic [63:0] core_data_out;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        out_encr_decr;
    logic        busy;
    logic        timeout_err;

    modport slave (
        input  in_valid, in_data, in_encr_decr,
        input  core_done, core_data_out, out_ready,
        output in_ready, core_start, core_data_in, core_encr_decr,
        output out_valid, out_data, out_encr_decr, busy, timeout_err
    );

    modport master (
        output in_valid, in_data, in_encr_decr,
        output core_done, core_data_out, out_ready,
        input  in_ready, core_start, core_data_in, core_encr_decr,
        input  out_valid, out_data, out_encr_decr, busy, timeout_err
    );
endinterface

// File: rtl/magma_block_sequencer.sv
// Feeds 64-bit blocks from a FIFO to the Magma core one at a time (ECB),
// holding operands stable and registering each result for a valid/ready sink.
module magma_block_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 63
) (
    input logic clk,
    input logic reset_,
    magma_block_sequencer_if.slave bus
);
    localparam int          AW     = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL   = (AW+1)'(FIFO_DEPTH);
    localparam logic [7:0]  TMO    = 8'(TIMEOUT);
    localparam logic [1:0]  S_IDLE = 2'd0;
    localparam logic [1:0]  S_LNCH = 2'd1;
    localparam logic [1:0]  S_WAIT = 2'd2;

    logic [64:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [1:0]    state_q, state_d;
    logic [7:0]    tmr_q, tmr_d;
    logic [63:0]   cdat_q, cdat_d, odat_q, odat_d;
    logic          cmode_q, cmode_d, omode_q, omode_d;
    logic          oval_q, oval_d, err_q, err_d;
    logic          push, pop;

    // A full FIFO stays full for the cycle even if a pop happens.
    assign bus.in_ready = !reset_ && (cnt_q != FULL);
    assign push         = bus.in_valid && bus.in_ready;

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        cdat_d  = cdat_q;
        cmode_d = cmode_q;
        odat_d  = odat_q;
        omode_d = omode_q;
        oval_d  = oval_q;
        err_d   = err_q;
        pop     = 1'b0;
        if (oval_q && bus.out_ready) oval_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (cnt_q != '0 && !oval_q) begin
                    pop               = 1'b1;
                    {cmode_d, cdat_d} = mem_q[rptr_q];
                    state_d           = S_LNCH;
                end
            end
            S_LNCH: begin
                tmr_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.core_done) begin
                    odat_d  = bus.core_data_out;
                    omode_d = cmode_q;
                    oval_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmr_d = tmr_q + 8'd1;
                    if (tmr_d == TMO) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wptr_d = push ? wptr_q + AW'(1) : wptr_q;
        rptr_d = pop  ? rptr_q + AW'(1) : rptr_q;
        cnt_d  = cnt_q;
        if (push && !pop) cnt_d = cnt_q + (AW+1)'(1);
        if (!push && pop) cnt_d = cnt_q - (AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= {bus.in_encr_decr, bus.in_data};
    end

    always_ff @(posedge clk) begin
        if (reset_) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            state_q <= S_IDLE;
            tmr_q   <= '0;
            cdat_q  <= '0;
            cmode_q <= 1'b0;
            odat_q  <= '0;
            omode_q <= 1'b0;
            oval_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            tmr_q   <= tmr_d;
            cdat_q  <= cdat_d;
            cmode_q <= cmode_d;
            odat_q  <= odat_d;
            omode_q <= omode_d;
            oval_q  <= oval_d;
            err_q   <= err_d;
        end
    end

    assign bus.core_start     = (state_q == S_LNCH);
    assign bus.core_data_in   = cdat_q;
    assign bus.core_encr_decr = cmode_q;
    assign bus.out_valid      = oval_q;
    assign bus.out_data       = odat_q;
    assign bus.out_encr_decr  = omode_q;
    assign bus.busy           = (state_q != S_IDLE) || (cnt_q != '0);
    assign bus.timeout_err    = err_q;
endmodule

// File: tb/tb_magma_block_sequencer.sv
// Bench for magma_block_sequencer: behavioural core model, result scoreboard,
// vector table, directed corner sequences and a randomized stream.
module tb_magma_block_sequencer;
    localparam int TIMEOUT = 63;

    typedef struct {
        logic [63:0] d;
        logic        m;
        int          lat;
        logic [63:0] xd;
        logic        xm;
    } vec_t;

    logic clk = 1'b0;
    logic reset_;
    always #5 clk = ~clk;

    magma_block_sequencer_if bif();

    magma_block_sequencer #(.FIFO_DEPTH(4), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk),
        .reset_(reset_),
        .bus(bif)
    );

    int checks = 0;
    int fails = 0;
    logic [64:0] expq[$];

    bit ordy = 1'b0;
    bit rnd = 1'b0;
    bit rnd_rdy = 1'b0;
    assign bif.out_ready = rnd ? rnd_rdy : ordy;

    function automatic logic [63:0] ref_core(input logic [63:0] d, input logic m);
        if (m && d == 64'hfedcba9876543210) return 64'h2be3e3aba70f6dd2;
        if (!m && d == 64'h2be3e3aba70f6dd2) return 64'hfedcba9876543210;
        return m ? ~d : d ^ 64'h0f0f0f0f0f0f0f0f;
    endfunction

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s actual=%h expected=%h", nm, a, e);
        end
    endtask

    // Core model: answers each start after cur_lat cycles unless it "hangs".
    int lat_next = 34;
    int starts = 0;
    int viol = 0;
    int cyc = 0;
    int cur_lat = 0;
    bit act = 1'b0;
    bit spur = 1'b0;
    logic done_r = 1'b0;
    logic [63:0] res_q = '0;
    logic [63:0] lat_d = '0;
    logic lat_m = 1'b0;
    assign bif.core_done = done_r | spur;
    assign bif.core_data_out = spur ? 64'hdeadbeef0badf00d : res_q;

    always @(negedge clk) begin
        done_r = 1'b0;
        if (reset_ === 1'b1) act = 1'b0;
        else if (bif.core_start === 1'b1) begin
            starts++;
            act = 1'b1;
            cyc = 0;
            lat_d = bif.core_data_in;
            lat_m = bif.core_encr_decr;
            cur_lat = rnd ? int'($urandom_range(1, 20)) : lat_next;
            res_q = ref_core(lat_d, lat_m);
        end else if (act) begin
            if (bif.core_data_in !== lat_d || bif.core_encr_decr !== lat_m) viol++;
            cyc++;
            if (cyc == cur_lat) begin
                act = 1'b0;
                done_r = 1'b1;
            end
        end
    end

    // Result monitor / scoreboard.
    always begin
        logic [64:0] e;
        logic rdy;
        @(negedge clk);
        #2;
        rnd_rdy = 1'($urandom_range(0, 1));
        rdy = rnd ? rnd_rdy : ordy;
        if (reset_ === 1'b0 && bif.out_valid === 1'b1 && rdy) begin
            if (expq.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_out actual=%h expected=none", bif.out_data);
            end else begin
                e = expq.pop_front();
                chk("out_data", bif.out_data, e[63:0]);
                chk("out_mode", 64'(bif.out_encr_decr), 64'(e[64]));
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [63:0] d, input logic m, input bit ex,
                        input logic [64:0] xv);
        int w = 0;
        step();
        bif.in_valid = 1'b1;
        bif.in_data = d;
        bif.in_encr_decr = m;
        while (!bif.in_ready && w < 500) begin
            step();
            w++;
        end
        checks++;
        if (w >= 500) begin
            fails++;
            $display("FAIL push_timeout actual=in_ready_low required=accept");
        end else if (ex) expq.push_back(xv);
        step();
        bif.in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int w = 0;
        while ((expq.size() != 0 || bif.busy || bif.out_valid) && w < budget) begin
            step();
            w++;
        end
        checks++;
        if (w >= budget) begin
            fails++;
            $display("FAIL drain_timeout actual=%0d_pending required=0", expq.size());
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[5];
        int s0;
        int w;
        logic [63:0] d;
        logic m;
        vt[0] = '{64'hfedcba9876543210, 1'b1, 34, 64'h2be3e3aba70f6dd2, 1'b1};
        vt[1] = '{64'h2be3e3aba70f6dd2, 1'b0, 34, 64'hfedcba9876543210, 1'b0};
        vt[2] = '{64'h0000000000000000, 1'b1, 1, 64'hffffffffffffffff, 1'b1};
        vt[3] = '{64'h0123456789abcdef, 1'b0, TIMEOUT, 64'h0e2c4a6886a4c2e0, 1'b0};
        vt[4] = '{64'haaaaaaaaaaaaaaaa, 1'b1, 5, 64'h5555555555555555, 1'b1};

        reset_ = 1'b1;
        bif.in_valid = 1'b0;
        bif.in_data = '0;
        bif.in_encr_decr = 1'b0;
        repeat (3) step();
        chk("rst_in_ready", 64'(bif.in_ready), 64'd0);
        chk("rst_out_valid", 64'(bif.out_valid), 64'd0);
        chk("rst_busy", 64'(bif.busy), 64'd0);
        chk("rst_start", 64'(bif.core_start), 64'd0);
        chk("rst_err", 64'(bif.timeout_err), 64'd0);
        chk("rst_core_data", bif.core_data_in, 64'd0);
        reset_ = 1'b0;
        ordy = 1'b1;
        step();
        chk("post_rst_ready", 64'(bif.in_ready), 64'd1);

        foreach (vt[i]) begin
            lat_next = vt[i].lat;
            s0 = starts;
            push(vt[i].d, vt[i].m, 1'b1, {vt[i].xm, vt[i].xd});
            wait_drain(200);
            chk("vec_starts", 64'(starts - s0), 64'd1);
            chk("vec_err", 64'(bif.timeout_err), 64'd0);
        end

        // Back-pressure: one result held, four buffered, FIFO full.
        ordy = 1'b0;
        lat_next = 3;
        s0 = starts;
        for (int i = 0; i < 5; i++) begin
            d = 64'h1000 + 64'(i);
            push(d, i[0], 1'b1, {i[0], ref_core(d, i[0])});
        end
        repeat (20) step();
        chk("bp_in_ready", 64'(bif.in_ready), 64'd0);
        chk("bp_starts", 64'(starts - s0), 64'd1);
        chk("bp_out_valid", 64'(bif.out_valid), 64'd1);
        ordy = 1'b1;
        push(64'h1005, 1'b1, 1'b1, {1'b1, ref_core(64'h1005, 1'b1)});
        wait_drain(300);
        chk("bp_all_starts", 64'(starts - s0), 64'd6);

        // Core never answers: timeout flagged exactly TIMEOUT+1 after start.
        lat_next = 1000;
        s0 = starts;
        push(64'h1111111111111111, 1'b1, 1'b0, '0);
        w = 0;
        while (starts == s0 && w < 50) begin
            step();
            w++;
        end
        chk("to_start", 64'(starts - s0), 64'd1);
        repeat (TIMEOUT) step();
        chk("to_err_early", 64'(bif.timeout_err), 64'd0);
        step();
        chk("to_err_set", 64'(bif.timeout_err), 64'd1);
        chk("to_busy", 64'(bif.busy), 64'd0);
        chk("to_no_out", 64'(bif.out_valid), 64'd0);
        lat_next = 10;
        s0 = starts;
        push(64'h2222222222222222, 1'b0, 1'b1, {1'b0, ref_core(64'h2222222222222222, 1'b0)});
        wait_drain(200);
        chk("to_next_starts", 64'(starts - s0), 64'd1);
        chk("to_err_sticky", 64'(bif.timeout_err), 64'd1);

        // Reset while waiting with three blocks queued.
        lat_next = 50;
        for (int i = 0; i < 4; i++) push(64'h3000 + 64'(i), 1'b1, 1'b0, '0);
        repeat (3) step();
        reset_ = 1'b1;
        step();
        chk("mid_rst_busy", 64'(bif.busy), 64'd0);
        chk("mid_rst_out_valid", 64'(bif.out_valid), 64'd0);
        chk("mid_rst_in_ready", 64'(bif.in_ready), 64'd0);
        chk("mid_rst_err", 64'(bif.timeout_err), 64'd0);
        step();
        reset_ = 1'b0;
        s0 = starts;
        repeat (80) step();
        chk("mid_rst_no_start", 64'(starts - s0), 64'd0);
        chk("mid_rst_idle", 64'(bif.busy), 64'd0);

        // Simultaneous push/pop at count 2, spurious done while idle.
        ordy = 1'b0;
        lat_next = 3;
        s0 = starts;
        for (int i = 0; i < 3; i++) begin
            d = 64'h4000 + 64'(i);
            push(d, 1'b0, 1'b1, {1'b0, ref_core(d, 1'b0)});
        end
        repeat (10) step();
        spur = 1'b1;
        step();
        spur = 1'b0;
        chk("spur_out_data", bif.out_data, ref_core(64'h4000, 1'b0));
        chk("spur_out_valid", 64'(bif.out_valid), 64'd1);
        chk("spur_starts", 64'(starts - s0), 64'd1);
        lat_next = 40;
        ordy = 1'b1;
        step();
        bif.in_valid = 1'b1;
        bif.in_data = 64'h4003;
        bif.in_encr_decr = 1'b0;
        chk("simul_ready", 64'(bif.in_ready), 64'd1);
        expq.push_back({1'b0, ref_core(64'h4003, 1'b0)});
        step();
        bif.in_valid = 1'b0;
        push(64'h4004, 1'b0, 1'b1, {1'b0, ref_core(64'h4004, 1'b0)});
        chk("simul_cnt3_ready", 64'(bif.in_ready), 64'd1);
        push(64'h4005, 1'b0, 1'b1, {1'b0, ref_core(64'h4005, 1'b0)});
        chk("simul_cnt4_full", 64'(bif.in_ready), 64'd0);
        wait_drain(500);

        // Randomized stream with random back-pressure and core latency.
        rnd = 1'b1;
        for (int i = 0; i < 120; i++) begin
            repeat ($urandom_range(0, 3)) step();
            d = {$urandom, $urandom};
            m = 1'($urandom_range(0, 1));
            push(d, m, 1'b1, {m, ref_core(d, m)});
        end
        wait_drain(3000);
        rnd = 1'b0;

        chk("operand_stable", 64'(viol), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
